// File: rtl/iir_out_requant.sv
// Output requantizer for a wide IIR filter: decimates, rounds half-up, saturates
// to OUT_WIDTH and buffers results in a first-word-fall-through FIFO.
module iir_out_requant #(
  parameter int IN_WIDTH  = 30,
  parameter int OUT_WIDTH = 14,
  parameter int SHIFT     = 15,
  parameter int DEC       = 1,
  parameter int DEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [IN_WIDTH-1:0]      din,
  input  logic                     din_valid,
  output logic [OUT_WIDTH-1:0]     dout,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     sat_flag,
  input  logic                     sat_clr,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (DEC > 1) ? $clog2(DEC) : 1;
  localparam int CW    = ((IN_WIDTH + 1) > OUT_WIDTH ? (IN_WIDTH + 1) : OUT_WIDTH) + 1;

  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEC - 1);
  localparam logic [IN_WIDTH:0]    HALF     = {{IN_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [CW-1:0] SAT_MAX  = ({{(CW-1){1'b0}}, 1'b1} << (OUT_WIDTH - 1))
                                              - {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [AW:0]          LVL_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]          LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]        PTR_ONE  = AW'(1'b1);

  logic [CNT_W-1:0]           cnt_r;
  logic                       s1_valid_r;
  logic [OUT_WIDTH-1:0]       s1_data_r;
  logic                       sat_flag_r;

  logic [OUT_WIDTH-1:0]       mem_r [DEPTH];
  logic [AW-1:0]              wr_ptr_r;
  logic [AW-1:0]              rd_ptr_r;
  logic [AW:0]                level_r;
  logic [OUT_WIDTH-1:0]       dout_r;
  logic                       dout_valid_r;
  logic [15:0]                drop_cnt_r;

  logic                       accept_s;
  logic signed [IN_WIDTH:0]   r_s;
  logic signed [IN_WIDTH:0]   q_s;
  logic signed [CW-1:0]       q_ext_s;
  logic [OUT_WIDTH-1:0]       sat_val_s;
  logic                       sat_s;

  logic                       pop_s;
  logic                       full_s;
  logic                       push_s;
  logic                       drop_s;
  logic [AW-1:0]              rd_next_s;
  logic [AW:0]                level_nxt_s;
  logic [OUT_WIDTH-1:0]       head_nxt_s;

  // Round half up (toward +inf) then clamp into the output range
  always_comb begin
    accept_s  = din_valid && (cnt_r == {CNT_W{1'b0}});
    r_s       = $signed({din[IN_WIDTH-1], din}) + $signed(HALF);
    q_s       = r_s >>> SHIFT;
    q_ext_s   = CW'(q_s);
    sat_val_s = {OUT_WIDTH{1'b0}};
    sat_s     = 1'b0;
    if (q_ext_s > SAT_MAX) begin
      sat_val_s = SAT_MAX[OUT_WIDTH-1:0];
      sat_s     = 1'b1;
    end else if (q_ext_s < SAT_MIN) begin
      sat_val_s = SAT_MIN[OUT_WIDTH-1:0];
      sat_s     = 1'b1;
    end else begin
      sat_val_s = q_ext_s[OUT_WIDTH-1:0];
      sat_s     = 1'b0;
    end
  end

  // Decimation phase, stage-1 result register and sticky saturation flag
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      s1_valid_r <= 1'b0;
      s1_data_r  <= {OUT_WIDTH{1'b0}};
      sat_flag_r <= 1'b0;
    end else begin
      if (din_valid) begin
        if (cnt_r == CNT_LAST) begin
          cnt_r <= {CNT_W{1'b0}};
        end else begin
          cnt_r <= cnt_r + CNT_W'(1'b1);
        end
      end
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_data_r <= sat_val_s;
      end
      // A new saturation wins over a coincident clear
      if (accept_s && sat_s) begin
        sat_flag_r <= 1'b1;
      end else if (sat_clr) begin
        sat_flag_r <= 1'b0;
      end
    end
  end

  // FIFO control and next head value, so dout can be held in a register
  always_comb begin
    pop_s     = dout_valid_r && dout_ready;
    full_s    = (level_r == LVL_FULL);
    push_s    = s1_valid_r && (!full_s || pop_s);
    drop_s    = s1_valid_r && full_s && !pop_s;
    rd_next_s = rd_ptr_r + PTR_ONE;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
    // Pop of the last entry with a push means the pushed word becomes the head
    if (level_nxt_s == {(AW+1){1'b0}}) begin
      head_nxt_s = {OUT_WIDTH{1'b0}};
    end else if (pop_s) begin
      if (level_r == LVL_ONE) begin
        head_nxt_s = s1_data_r;
      end else begin
        head_nxt_s = mem_r[rd_next_s];
      end
    end else if (level_r == {(AW+1){1'b0}}) begin
      head_nxt_s = s1_data_r;
    end else begin
      head_nxt_s = dout_r;
    end
  end

  // FIFO storage, pointers, registered outputs and saturating drop counter
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {OUT_WIDTH{1'b0}};
      end
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      level_r      <= {(AW+1){1'b0}};
      dout_r       <= {OUT_WIDTH{1'b0}};
      dout_valid_r <= 1'b0;
      drop_cnt_r   <= 16'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= s1_data_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_next_s;
      end
      level_r      <= level_nxt_s;
      dout_valid_r <= (level_nxt_s != {(AW+1){1'b0}});
      dout_r       <= head_nxt_s;
      if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
        drop_cnt_r <= drop_cnt_r + 16'd1;
      end
    end
  end

  assign dout       = dout_r;
  assign dout_valid = dout_valid_r;
  assign sat_flag   = sat_flag_r;
  assign drop_cnt   = drop_cnt_r;
  assign fifo_level = level_r;

endmodule

// File: tb/tb_iir_out_requant.sv
// Directed bench for iir_out_requant: default instance plus a DEC=3 instance
// sharing the same stimulus.
module tb_iir_out_requant;

  logic        clk;
  logic        n_rst;
  logic [29:0] din;
  logic        din_valid;
  logic        dout_ready;
  logic        sat_clr;

  logic [13:0] dout;
  logic        dout_valid;
  logic        sat_flag;
  logic [15:0] drop_cnt;
  logic [2:0]  fifo_level;

  logic [13:0] d3_dout;
  logic        d3_dout_valid;
  logic        d3_sat_flag;
  logic [15:0] d3_drop_cnt;
  logic [2:0]  d3_fifo_level;

  int checks;
  int errors;
  int d3_q[$];

  iir_out_requant u_dut (
    .clk(clk), .n_rst(n_rst), .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .sat_flag(sat_flag), .sat_clr(sat_clr), .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  iir_out_requant #(.DEC(3)) u_dec3 (
    .clk(clk), .n_rst(n_rst), .din(din), .din_valid(din_valid),
    .dout(d3_dout), .dout_valid(d3_dout_valid), .dout_ready(dout_ready),
    .sat_flag(d3_sat_flag), .sat_clr(sat_clr), .drop_cnt(d3_drop_cnt),
    .fifo_level(d3_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; sample #1 later and log DEC=3 outputs as they appear
  task automatic tick();
    @(posedge clk);
    #1;
    if (d3_dout_valid) d3_q.push_back(int'($signed(d3_dout)));
  endtask

  task automatic set_din(input int v);
    din = v[29:0];
  endtask

  task automatic send_one(input string tag, input int v, input int exp);
    set_din(v);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk({tag, "_lat1"}, int'(dout_valid), 0);
    tick();
    chk({tag, "_valid"}, int'(dout_valid), 1);
    chk(tag, int'($signed(dout)), exp);
    tick();
  endtask

  task automatic pulse_reset();
    #2;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    n_rst      = 1'b0;
    din        = 30'd0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    sat_clr    = 1'b0;
    tick();
    tick();
    chk("rst_dout_valid", int'(dout_valid), 0);
    chk("rst_fifo_level", int'(fifo_level), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_sat_flag", int'(sat_flag), 0);
    chk("rst_drop_cnt", int'(drop_cnt), 0);
    n_rst = 1'b1;
    tick();

    // Basic conversion and two-edge latency
    dout_ready = 1'b1;
    send_one("basic_100", 100 * 32768, 100);
    chk("basic_empty_valid", int'(dout_valid), 0);
    chk("basic_empty_dout", int'(dout), 0);
    chk("basic_sat_flag", int'(sat_flag), 0);

    send_one("rnd_16384", 16384, 1);
    send_one("rnd_16383", 16383, 0);
    send_one("rnd_m16384", -16384, 0);
    send_one("rnd_m16385", -16385, -1);
    chk("rnd_sat_flag", int'(sat_flag), 0);

    send_one("sat_pos", 536870911, 8191);
    send_one("sat_neg", -536870912, -8192);
    chk("sat_flag_set", int'(sat_flag), 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_flag_cleared", int'(sat_flag), 0);
    sat_clr = 1'b1;
    set_din(536870911);
    din_valid = 1'b1;
    tick();
    sat_clr   = 1'b0;
    din_valid = 1'b0;
    chk("sat_set_wins_clr", int'(sat_flag), 1);
    tick();
    chk("sat_coinc_dout", int'($signed(dout)), 8191);
    tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("sat_flag_cleared2", int'(sat_flag), 0);

    // Backpressure: six inputs into a four-deep FIFO
    dout_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      set_din(k * 32768);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    chk("bp_level_full", int'(fifo_level), 4);
    chk("bp_drop_cnt", int'(drop_cnt), 2);
    chk("bp_head_1", int'($signed(dout)), 1);
    set_din(9 * 32768);
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    chk("bp_hold_dout", int'($signed(dout)), 1);
    dout_ready = 1'b1;
    tick();
    chk("bp_pushpop_level", int'(fifo_level), 4);
    chk("bp_pushpop_drop", int'(drop_cnt), 2);
    chk("bp_out_2", int'($signed(dout)), 2);
    tick();
    chk("bp_out_3", int'($signed(dout)), 3);
    tick();
    chk("bp_out_4", int'($signed(dout)), 4);
    tick();
    chk("bp_out_9_wrap", int'($signed(dout)), 9);
    tick();
    chk("bp_drained_level", int'(fifo_level), 0);
    chk("bp_drained_dout", int'(dout), 0);
    tick();
    chk("bp_ready_empty_level", int'(fifo_level), 0);
    chk("bp_ready_empty_valid", int'(dout_valid), 0);

    // Asynchronous reset with three samples buffered
    dout_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      set_din(k * 32768);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    chk("mid_level_3", int'(fifo_level), 3);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", int'(dout_valid), 0);
    chk("mid_rst_level", int'(fifo_level), 0);
    chk("mid_rst_drop", int'(drop_cnt), 0);
    chk("mid_rst_dout", int'(dout), 0);
    tick();
    n_rst = 1'b1;
    dout_ready = 1'b1;
    send_one("post_rst_7", 7 * 32768, 7);

    // DEC=3 instance: only every third valid input survives, gaps ignored
    pulse_reset();
    d3_q.delete();
    for (int k = 0; k <= 8; k++) begin
      set_din(k * 32768);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      if (k % 2 == 1) tick();
    end
    for (int i = 0; i < 4; i++) tick();
    chk("dec3_count", d3_q.size(), 3);
    if (d3_q.size() == 3) begin
      chk("dec3_out0", d3_q[0], 0);
      chk("dec3_out1", d3_q[1], 3);
      chk("dec3_out2", d3_q[2], 6);
    end
    chk("dec3_drop", int'(d3_drop_cnt), 0);
    chk("dec3_level", int'(d3_fifo_level), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
